spi_master_seq: RTL and testbench
=================================

# spi_master_seq

Byte-oriented SPI master sequencer for the SPI_FPGA design, mode 0 (CPOL=0, CPHA=0), MSB first. It accepts a one-cycle `start` request with a transmit word and a speed select, and drives `cs`, `sclk` and `mosi` toward the `recievesend` slave. It samples `miso`, returns the received word with a one-cycle `done` pulse, and mirrors the low nibble on the board LEDs. It is the block that sequences every transfer on the SPI link; host logic never toggles SPI pins directly.

## Interface
- `WIDTH`, 8: bits per transfer; must be ≥ 2.
- `DIV_SLOW`, 8: sclk half-period in `clk` cycles when `speed`=0; must be ≥ 1.
- `DIV_FAST`, 2: sclk half-period in `clk` cycles when `speed`=1; must be ≥ 1.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  transfer request; honoured only when `busy`=0.
- `speed`  in  1  0 = slow (`DIV_SLOW`), 1 = fast (`DIV_FAST`); sampled with `start`.
- `tx_data`  in  WIDTH  word to send; sampled with `start`.
- `miso`  in  1  serial data from slave.
- `cs`  out  1  chip select, active low.
- `sclk`  out  1  SPI clock, idles low.
- `mosi`  out  1  serial data to slave.
- `rx_data`  out  WIDTH  last received word; updated only in the `done` cycle.
- `lds`  out  4  `rx_data[3:0]`, registered together with `rx_data`.
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle (exclusive).
- `done`  out  1  one-cycle pulse at transfer end.

## Operation
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, `lds`=0; state IDLE; all counters 0.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- On accepted `start`, latch H = `speed` ? `DIV_FAST` : `DIV_SLOW`, latch `tx_data` into the shift register, and clear the bit counter.
- IDLE: when `start`=1, go to SETUP. Otherwise remain.
- SETUP, H cycles: `cs`=0, `sclk`=0, `mosi`=tx bit WIDTH-1, then go to HIGH.
- HIGH, H cycles: `sclk`=1 and `mosi` holds. On the last cycle of the phase, shift `miso` into the receive register LSB and increment the bit counter. Then go to LOW.
- LOW, H cycles: `sclk`=0.
  - At phase entry, `mosi` advances to the next tx bit. After the final bit it holds its value.
  - At phase end, go to HIGH if bit counter < WIDTH, else go to DONE.
- DONE, 1 cycle: `cs`=1, `sclk`=0, `busy`=0, `done`=1; `rx_data`/`lds` take the receive register.
  - `start`=1 here is accepted and goes to SETUP, so `cs` is high for exactly 1 cycle between back-to-back transfers.
  - Otherwise go to IDLE.
- `start` while `busy`=1 is ignored. Changes to `tx_data`/`speed` during a transfer have no effect.
- Half-period counter width is `$clog2(max(DIV_SLOW, DIV_FAST)+1)`. The bit counter is `$clog2(WIDTH+1)` bits and never wraps within a transfer.
- Reset mid-transfer: on the next edge all outputs return to reset values. `rx_data` clears, no `done` is issued, and the partial word is discarded.
- `rst` and `start` asserted together: reset wins.

## Timing
- Cycle numbering: cycle 0 is the edge where `start` is sampled in IDLE.
- Cycle 1: `cs`=0, `busy`=1, `mosi`=MSB.
- Rising `sclk` edge k (k = 0..WIDTH-1) occurs at cycle 1+H+2H·k.
- `miso` for bit k is sampled at cycle 2H+2H·k, the last cycle of the high phase.
- `cs` is low for H·(2·WIDTH+1) cycles.
- `done`=1 at cycle 1+H·(2·WIDTH+1). For WIDTH=8 this is cycle 35 fast (H=2) and cycle 137 slow (H=8).
- Each `mosi` bit is stable for the whole high phase, with ≥ H cycles of setup before the rising edge and H cycles of hold after it.
- `sclk` is never high while `cs`=1.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → all outputs at reset values, `busy` never rises.
- Fast loopback: `miso`=`mosi`, `speed`=1, `tx_data`=0xA5, 1-cycle `start` → 8 sclk pulses of 2 high/2 low cycles. `mosi` sequence 1,0,1,0,0,1,0,1. `done` at cycle 35, `rx_data`=0xA5, `lds`=0x5, `cs` low for 34 cycles.
- Slow, `miso` tied 1, `tx_data`=0x00 → `done` at cycle 137, `rx_data`=0xFF, `mosi` 0 throughout.
- `start` pulsed at cycles 5 and 20 of a fast transfer with `tx_data`=0x3C → ignored. Exactly one `done`, `rx_data` (loopback) = the first word, 0xA5.
- Back-to-back: `start` held high with loopback, words 0x12 then 0x34 → `done` at cycles 35 and 70, `cs` high only in cycle 35, `rx_data`=0x12 then 0x34.
- `rst` asserted at cycle 20 of a fast transfer → cycle 21 has `cs`=1, `sclk`=0, `busy`=0, `rx_data`=0, and no `done`. A new `start` afterwards completes normally.

Source files
------------

// File: rtl/spi_master_seq.sv
// SPI mode 0 master sequencer: shifts one MSB-first word out on mosi while
// capturing miso, then returns the received word with a one-cycle done pulse.
module spi_master_seq #(
  parameter int WIDTH    = 8,
  parameter int DIV_SLOW = 8,
  parameter int DIV_FAST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             speed,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  output logic [WIDTH-1:0] rx_data,
  output logic [3:0]       lds,
  output logic             busy,
  output logic             done
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int HW      = $clog2(DIV_MAX + 1);
  localparam int BW      = $clog2(WIDTH + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [HW-1:0]    half;
  logic [HW-1:0]    hcnt;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] txsh;
  logic [WIDTH-1:0] rxsh;
  logic             phase_end;

  assign phase_end = (hcnt == half - HW'(1));

  // Pin levels are pure decodes of the state register, so a reset or an
  // aborted transfer can never leave sclk high with cs released.
  assign cs   = (state == IDLE) || (state == DONE);
  assign sclk = (state == HIGH);
  assign busy = (state == SETUP) || (state == HIGH) || (state == LOW);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      half    <= '0;
      hcnt    <= '0;
      bitcnt  <= '0;
      txsh    <= '0;
      rxsh    <= '0;
      mosi    <= 1'b0;
      rx_data <= '0;
      lds     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= SETUP;
            half   <= speed ? HW'(DIV_FAST) : HW'(DIV_SLOW);
            txsh   <= tx_data;
            mosi   <= tx_data[WIDTH-1];
            rxsh   <= '0;
            bitcnt <= '0;
            hcnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state <= HIGH;
            hcnt  <= '0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            state  <= LOW;
            hcnt   <= '0;
            rxsh   <= {rxsh[WIDTH-2:0], miso};
            bitcnt <= bitcnt + BW'(1);
            // mosi moves on as the low phase starts; the last bit is held
            if (bitcnt < BW'(WIDTH - 1)) begin
              mosi <= txsh[WIDTH-2];
              txsh <= {txsh[WIDTH-2:0], 1'b0};
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        LOW: begin
          if (phase_end) begin
            hcnt <= '0;
            if (bitcnt < BW'(WIDTH)) begin
              state <= HIGH;
            end else begin
              state   <= DONE;
              rx_data <= rxsh;
              lds     <= rxsh[3:0];
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: loopback, tied miso, ignored starts,
// back-to-back transfers and reset behaviour, with hand-computed expectations.
module tb_spi_master_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       speed;
  logic [7:0] tx_data;
  logic       miso;
  logic       cs, sclk, mosi, busy, done;
  logic [7:0] rx_data;
  logic [3:0] lds;

  logic loop    = 1'b1;
  logic misofix = 1'b0;

  int checks   = 0;
  int failures = 0;

  assign miso = loop ? mosi : misofix;

  always #5 clk = ~clk;

  spi_master_seq #(.WIDTH(8), .DIV_SLOW(8), .DIV_FAST(2)) dut (
    .clk(clk), .rst(rst), .start(start), .speed(speed), .tx_data(tx_data),
    .miso(miso), .cs(cs), .sclk(sclk), .mosi(mosi), .rx_data(rx_data),
    .lds(lds), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer from the start request to the done cycle (or a budget),
  // collecting cycle counts, the mosi bit seen at each rising sclk, and
  // protocol violations. Cycle 1 is the first cycle after start is sampled.
  task automatic applyStimulus(input logic [7:0] word, input logic spd, input logic hold,
                               input int ign_a, input int ign_b, input logic [7:0] ign_word,
                               output int done_cyc, output int cs_low, output int rises,
                               output logic [7:0] mosi_seq, output logic [7:0] rx_seen,
                               output logic [3:0] lds_seen, output int bad);
    int cyc;
    int hlen;
    int h;
    logic prev_sclk;
    logic rise_mosi;
    logic [7:0] rx_before;
    h = spd ? 2 : 8;
    tx_data = word;
    speed = spd;
    start = 1'b1;
    rx_before = rx_data;
    step();
    cyc = 1;
    done_cyc = -1; cs_low = 0; rises = 0; mosi_seq = '0; rx_seen = '0; lds_seen = '0;
    bad = 0; hlen = 0; prev_sclk = 1'b0; rise_mosi = 1'b0;
    if (!hold) start = 1'b0;
    checkOutput("cycle1_cs", {31'd0, cs}, 32'd0);
    checkOutput("cycle1_busy", {31'd0, busy}, 32'd1);
    checkOutput("cycle1_mosi", {31'd0, mosi}, {31'd0, word[7]});
    while (cyc < 400 && done_cyc < 0) begin
      if (!cs) cs_low++;
      if (sclk && cs) bad++;
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_seq = {mosi_seq[6:0], mosi};
        rise_mosi = mosi;
        hlen = 0;
      end
      if (sclk) begin
        hlen++;
        if (mosi !== rise_mosi) bad++;
      end
      if (!sclk && prev_sclk && hlen != h) bad++;
      if (!done && rx_data !== rx_before) bad++;
      if (done) begin
        done_cyc = cyc;
        rx_seen = rx_data;
        lds_seen = lds;
      end else begin
        prev_sclk = sclk;
        if (!hold) begin
          if (cyc == ign_a || cyc == ign_b) begin
            start = 1'b1;
            tx_data = ign_word;
          end else begin
            start = 1'b0;
          end
        end
        step();
        cyc++;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  int d, cl, r, b, extra;
  logic [7:0] ms, rx;
  logic [3:0] ld;

  initial begin
    rst = 1'b1; start = 1'b1; speed = 1'b1; tx_data = 8'hFF;

    // Reset held with start asserted: busy must never rise.
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy || !cs || sclk || mosi || done || rx_data != 0 || lds != 0) extra++;
    end
    checkOutput("reset_outputs", extra, 0);
    checkOutput("reset_cs", {31'd0, cs}, 32'd1);
    rst = 1'b0; start = 1'b0;
    step();
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    // Fast loopback 0xA5.
    loop = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, -1, 8'h00, d, cl, r, ms, rx, ld, b);
    checkOutput("fast_done_cycle", d, 35);
    checkOutput("fast_cs_low", cl, 34);
    checkOutput("fast_rises", r, 8);
    checkOutput("fast_mosi_seq", {24'd0, ms}, 32'hA5);
    checkOutput("fast_rx", {24'd0, rx}, 32'hA5);
    checkOutput("fast_lds", {28'd0, ld}, 32'h5);
    checkOutput("fast_protocol", b, 0);
    step();
    checkOutput("fast_idle_after", {30'd0, busy, done}, 32'd0);

    // Slow transfer, miso tied high, all-zero word.
    loop = 1'b0; misofix = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, -1, -1, 8'h00, d, cl, r, ms, rx, ld, b);
    checkOutput("slow_done_cycle", d, 137);
    checkOutput("slow_cs_low", cl, 136);
    checkOutput("slow_rises", r, 8);
    checkOutput("slow_mosi_seq", {24'd0, ms}, 32'h00);
    checkOutput("slow_rx", {24'd0, rx}, 32'hFF);
    checkOutput("slow_lds", {28'd0, ld}, 32'hF);
    checkOutput("slow_protocol", b, 0);
    step();

    // Starts during a fast transfer are ignored.
    loop = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b0, 5, 20, 8'h3C, d, cl, r, ms, rx, ld, b);
    checkOutput("ign_done_cycle", d, 35);
    checkOutput("ign_rx", {24'd0, rx}, 32'hA5);
    checkOutput("ign_protocol", b, 0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) extra++;
    end
    checkOutput("ign_single_done", extra, 0);

    // Back-to-back with start held high.
    applyStimulus(8'h12, 1'b1, 1'b1, -1, -1, 8'h00, d, cl, r, ms, rx, ld, b);
    checkOutput("b2b1_done_cycle", d, 35);
    checkOutput("b2b1_rx", {24'd0, rx}, 32'h12);
    checkOutput("b2b1_cs_in_done", {31'd0, cs}, 32'd1);
    applyStimulus(8'h34, 1'b1, 1'b1, -1, -1, 8'h00, d, cl, r, ms, rx, ld, b);
    checkOutput("b2b2_done_cycle", d, 35);
    checkOutput("b2b2_rx", {24'd0, rx}, 32'h34);
    checkOutput("b2b2_lds", {28'd0, ld}, 32'h4);
    checkOutput("b2b2_protocol", b, 0);
    start = 1'b0;
    step();

    // Reset at cycle 20 of a fast transfer.
    tx_data = 8'hA5; speed = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_cs", {31'd0, cs}, 32'd1);
    checkOutput("midrst_sclk", {31'd0, sclk}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_rx", {24'd0, rx_data}, 32'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) extra++;
    end
    checkOutput("midrst_quiet", extra, 0);

    applyStimulus(8'h5A, 1'b1, 1'b0, -1, -1, 8'h00, d, cl, r, ms, rx, ld, b);
    checkOutput("post_done_cycle", d, 35);
    checkOutput("post_rx", {24'd0, rx}, 32'h5A);
    checkOutput("post_lds", {28'd0, ld}, 32'hA);
    checkOutput("post_protocol", b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
